elastic_pipe: RTL

- Linear valid/accept pipeline of N identical stages. Each stage is a D-entry in-order buffer with a registered accept and its own stall request.
- Successor to the fixed double-buffer stage chain. Generalises the per-stage depth to D (D=2 is the double-buffer case).
- Adds downstream backpressure on the last stage, a global synchronous flush, and a registered total-occupancy output.
- Used wherever a stallable multi-stage datapath needs full throughput with registered-only handshakes between stages.

---
 rtl/elastic_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/elastic_pipe.sv
// In-order D-entry buffer used as one elastic stage: registered storage, pointers and count.
// Latency: a word pushed into an empty buffer is the head entry one edge later.
// Backpressure: none inside; the caller pushes only against a slot it has already reserved.
module elastic_fifo #(
   parameter  int W  = 32,
   parameter  int D  = 2,
   localparam int CW = $clog2(D + 1),
   localparam int PW = (D > 1) ? $clog2(D) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wr_dat,
   output logic [W-1:0]  head_dat,
   output logic [CW-1:0] cnt,
   output logic [CW-1:0] cnt_nxt
);

   logic [W-1:0]  mem [D];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // D need not be a power of two, so wrap on an explicit compare.
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(D - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      cnt_nxt = cnt;
      if (clr)
         cnt_nxt = '0;
      else if (push && !pop)
         cnt_nxt = cnt + 1'b1;
      else if (pop && !push)
         cnt_nxt = cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int j = 0; j < D; j++)
            mem[j] <= '0;
      end else if (clr) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (push) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wrap_inc(wr_ptr);
         end
         if (pop)
            rd_ptr <= wrap_inc(rd_ptr);
      end
   end

   assign head_dat = mem[rd_ptr];

endmodule

// Linear valid/accept pipeline of N elastic stages with per-stage stall, flush and occupancy.
// Latency: N edges from input accept to output valid on an empty, unstalled pipe; 1 word/cycle.
// Backpressure: out_accept low fills stages back to front; in_accept is registered and drops once stage 0 is full.
module elastic_pipe #(
   parameter  int N  = 4,
   parameter  int W  = 32,
   parameter  int D  = 2,
   localparam int OW = $clog2(N * D + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  in,
   input  logic          in_vld,
   output logic          in_accept,
   output logic [W-1:0]  out_r,
   output logic          out_vld_r,
   input  logic          out_accept,
   input  logic [N-1:0]  stall_req,
   input  logic          flush,
   output logic [OW-1:0] occ_r
);

   localparam int CW = $clog2(D + 1);

   logic [N-1:0]  vld;
   logic [N-1:0]  up_vld;
   logic [N-1:0]  push;
   logic [N-1:0]  pop;
   logic [N-1:0]  dn_accept;
   logic [N-1:0]  accept_r;
   logic [W-1:0]  up_dat  [N];
   logic [W-1:0]  head    [N];
   logic [CW-1:0] cnt     [N];
   logic [CW-1:0] cnt_nxt [N];
   logic [OW-1:0] occ_nxt;

   // A single-entry stage cannot accept while it drains, which halves throughput.
   if (D < 2) begin : g_depth_check
      $error("elastic_pipe: D must be at least 2");
   end

   for (genvar i = 0; i < N; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign up_vld[i] = in_vld;
         assign up_dat[i] = in;
      end else begin : g_link
         assign up_vld[i] = vld[i-1];
         assign up_dat[i] = head[i-1];
      end

      if (i == N - 1) begin : g_last
         assign dn_accept[i] = out_accept;
      end else begin : g_mid
         assign dn_accept[i] = accept_r[i+1];
      end

      assign vld[i]  = (cnt[i] != '0) && !stall_req[i];
      assign push[i] = up_vld[i] && accept_r[i];
      assign pop[i]  = vld[i] && dn_accept[i];

      elastic_fifo #(
         .W (W),
         .D (D)
      ) u_buf (
         .clk      (clk),
         .rst      (rst),
         .clr      (flush),
         .push     (push[i]),
         .pop      (pop[i]),
         .wr_dat   (up_dat[i]),
         .head_dat (head[i]),
         .cnt      (cnt[i]),
         .cnt_nxt  (cnt_nxt[i])
      );
   end

   // cnt_nxt already reads 0 under flush, so the same rule yields accept = !stall then.
   always_ff @(posedge clk) begin
      if (rst)
         accept_r <= '1;
      else
         for (int i = 0; i < N; i++)
            accept_r[i] <= !stall_req[i] && (cnt_nxt[i] < CW'(D));
   end

   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < N; i++)
         occ_nxt = occ_nxt + OW'(cnt_nxt[i]);
   end

   always_ff @(posedge clk) begin
      if (rst)
         occ_r <= '0;
      else
         occ_r <= occ_nxt;
   end

   assign in_accept = accept_r[0];
   assign out_r     = head[N-1];
   assign out_vld_r = vld[N-1];

endmodule
